// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline controller for a six-stage in-order core. It turns stall
// requests from decode, execute and memory into per-stage hold signals,
// redirects the front end on exceptions / exception returns with a one-cycle
// flush, counts stalled cycles, and raises a sticky watchdog flag when the
// pipeline has been stalled for too long without a break.
//
// Parameters
//   TIMEOUT_CYCLES  consecutive stalled cycles that raise timeout (2..65535)
//
// Ports
//   clk           in   sole clock, rising edge
//   rst           in   synchronous active-low reset
//   stallreq_id   in   decode stall request (load-use hazard), level
//   stallreq_ex   in   execute stall request (multi-cycle op), level
//   stallreq_mem  in   memory stall request (bus wait), level
//   excep_req     in   exception pulse from memory stage
//   excep_vector  in   handler address, valid with excep_req
//   eret_req      in   exception-return pulse from memory stage
//   epc           in   return address, valid with eret_req
//   stall         out  per-stage hold: [0] PC .. [5] WB
//   flush         out  one-cycle pulse clearing all pipeline registers
//   new_pc        out  redirect target, valid while flush is high
//   stall_cnt     out  saturating count of cycles with any stage held
//   timeout       out  sticky stall-watchdog flag
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        excep_req,
   input  logic [31:0] excep_vector,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cnt,
   output logic        timeout
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // The run counter saturates at this value; reaching it while still
   // stalled is what trips the watchdog.
   localparam logic [15:0] RUN_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] run_cnt_q, run_cnt_d;
   logic        timeout_q, timeout_d;
   logic        stall_active;

   // Hold decode: the deepest requesting stage freezes itself and everything
   // upstream of it. During the flush cycle nothing is held so the cleared
   // pipeline can restart at the redirect target.
   always_comb begin
      stall = 6'b000000;
      if (state_q == ST_RUN) begin
         if (stallreq_mem) begin
            stall = 6'b011111;
         end else if (stallreq_ex) begin
            stall = 6'b001111;
         end else if (stallreq_id) begin
            stall = 6'b000111;
         end
      end
   end

   assign stall_active = (stall != 6'b000000);

   // Next-state logic for the RUN/FLUSH machine and the redirect target.
   // Exceptions take priority over eret, and either one is accepted even
   // with a stall pending because the flush throws that work away anyway.
   // FLUSH always returns to RUN and ignores every request it sees.
   always_comb begin
      state_d  = ST_RUN;
      flush_d  = 1'b0;
      new_pc_d = new_pc_q;
      if (state_q == ST_RUN) begin
         if (excep_req) begin
            state_d  = ST_FLUSH;
            flush_d  = 1'b1;
            new_pc_d = excep_vector;
         end else if (eret_req) begin
            state_d  = ST_FLUSH;
            flush_d  = 1'b1;
            new_pc_d = epc;
         end
      end
   end

   // Statistics and watchdog. stall_cnt never wraps; the run counter tracks
   // only the current unbroken stall streak and saturates once it reaches
   // the limit, at which point timeout latches until reset.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      run_cnt_d   = 16'd0;
      timeout_d   = timeout_q;
      if (stall_active) begin
         if (stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
         if (run_cnt_q == RUN_LIMIT) begin
            run_cnt_d = run_cnt_q;
            timeout_d = 1'b1;
         end else begin
            run_cnt_d = run_cnt_q + 16'd1;
         end
      end
   end

   // All state in one register bank. Reset is synchronous and beats any
   // exception or eret presented in the same cycle, and also aborts a flush
   // in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         flush_q     <= 1'b0;
         new_pc_q    <= 32'h0;
         stall_cnt_q <= 32'h0;
         run_cnt_q   <= 16'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_q     <= flush_d;
         new_pc_q    <= new_pc_d;
         stall_cnt_q <= stall_cnt_d;
         run_cnt_q   <= run_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign flush     = flush_q;
   assign new_pc    = new_pc_q;
   assign stall_cnt = stall_cnt_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl with a short watchdog (TIMEOUT_CYCLES=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// i.e. well away from the rising edge that updates the DUT.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int T = 4;

   logic        clk;
   logic        rst;
   logic        stallreq_id, stallreq_ex, stallreq_mem;
   logic        excep_req, eret_req;
   logic [31:0] excep_vector, epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cnt;
   logic        timeout;

   int n_checks = 0;
   int n_err    = 0;

   pipe_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .excep_req    (excep_req),
      .excep_vector (excep_vector),
      .eret_req     (eret_req),
      .epc          (epc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .stall_cnt    (stall_cnt),
      .timeout      (timeout)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Directed vector: inputs for one cycle plus the outputs expected during
   // that same cycle (before the edge that consumes the inputs).
   typedef struct {
      bit          r_rst, r_id, r_ex, r_mem, r_exc, r_eret;
      logic [31:0] r_vec, r_epc;
      logic [5:0]  e_stall;
      bit          e_flush;
      logic [31:0] e_pc;
      logic [31:0] e_cnt;
      bit          e_to;
   } row_t;

   row_t rows[$];

   // Behavioural reference: a stall streak length, a plain integer stall
   // tally and a "flushing now" flag are all that is needed.
   bit              m_flush;
   logic [31:0]     m_pc;
   longint unsigned m_cnt;
   int              m_run;
   bit              m_to;

   function automatic logic [5:0] modelStall();
      int depth;
      if (m_flush) return 6'b0;
      depth = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : 0;
      return 6'((1 << depth) - 1);
   endfunction

   // Advance the reference by one rising edge using the inputs now applied.
   task automatic modelEdge();
      logic [5:0] s;
      if (!rst) begin
         m_flush = 1'b0; m_pc = 32'h0; m_cnt = 0; m_run = 0; m_to = 1'b0;
      end else begin
         s = modelStall();
         if (s != 6'b0) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            m_run++;
            if (m_run >= T) m_to = 1'b1;
         end else begin
            m_run = 0;
         end
         if (!m_flush && (excep_req || eret_req)) begin
            m_flush = 1'b1;
            m_pc    = excep_req ? excep_vector : epc;
         end else begin
            m_flush = 1'b0;
         end
      end
   endtask

   task automatic applyStimulus(input bit a_rst, input bit a_id, input bit a_ex,
                                input bit a_mem, input bit a_exc, input bit a_eret,
                                input logic [31:0] a_vec, input logic [31:0] a_epc);
      rst          = a_rst;
      stallreq_id  = a_id;
      stallreq_ex  = a_ex;
      stallreq_mem = a_mem;
      excep_req    = a_exc;
      eret_req     = a_eret;
      excep_vector = a_vec;
      epc          = a_epc;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic finishCycle();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
   endtask

   task automatic addRow(input bit a_rst, input bit a_id, input bit a_ex,
                         input bit a_mem, input bit a_exc, input bit a_eret,
                         input logic [31:0] a_vec, input logic [31:0] a_epc,
                         input logic [5:0] x_stall, input bit x_flush,
                         input logic [31:0] x_pc, input logic [31:0] x_cnt,
                         input bit x_to);
      row_t r;
      r.r_rst = a_rst; r.r_id = a_id; r.r_ex = a_ex; r.r_mem = a_mem;
      r.r_exc = a_exc; r.r_eret = a_eret; r.r_vec = a_vec; r.r_epc = a_epc;
      r.e_stall = x_stall; r.e_flush = x_flush; r.e_pc = x_pc;
      r.e_cnt = x_cnt; r.e_to = x_to;
      rows.push_back(r);
   endtask

   initial begin
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      m_flush = 1'b0; m_pc = 32'h0; m_cnt = 0; m_run = 0; m_to = 1'b0;

      //      rst id ex mem exc eret vec      epc       stall     fl pc       cnt to
      addRow(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000000, 0, 32'h0,   0, 0);
      addRow(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000111, 0, 32'h0,   0, 0);
      addRow(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000111, 0, 32'h0,   1, 0);
      addRow(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000111, 0, 32'h0,   2, 0);
      addRow(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000000, 0, 32'h0,   3, 0);
      addRow(1, 1, 1, 1, 0, 0, 32'h0,   32'h0,   6'b011111, 0, 32'h0,   3, 0);
      addRow(1, 1, 1, 0, 0, 0, 32'h0,   32'h0,   6'b001111, 0, 32'h0,   4, 0);
      addRow(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000111, 0, 32'h0,   5, 0);
      addRow(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000000, 0, 32'h0,   6, 0);
      addRow(1, 0, 1, 0, 1, 0, 32'h20,  32'h0,   6'b001111, 0, 32'h0,   6, 0);
      addRow(1, 0, 1, 0, 0, 0, 32'h0,   32'h0,   6'b000000, 1, 32'h20,  7, 0);
      addRow(1, 0, 1, 0, 0, 0, 32'h0,   32'h0,   6'b001111, 0, 32'h20,  7, 0);
      addRow(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000000, 0, 32'h20,  8, 0);
      addRow(1, 0, 0, 0, 1, 1, 32'h20,  32'h100, 6'b000000, 0, 32'h20,  8, 0);
      addRow(1, 0, 0, 1, 1, 0, 32'h55,  32'h0,   6'b000000, 1, 32'h20,  8, 0);
      addRow(1, 0, 0, 0, 0, 1, 32'h0,   32'h100, 6'b000000, 0, 32'h20,  8, 0);
      addRow(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000000, 1, 32'h100, 8, 0);
      addRow(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000000, 0, 32'h100, 8, 0);
      addRow(1, 0, 0, 0, 1, 0, 32'h40,  32'h0,   6'b000000, 0, 32'h100, 8, 0);
      addRow(0, 0, 0, 0, 1, 0, 32'h80,  32'h0,   6'b000000, 1, 32'h40,  8, 0);
      addRow(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000000, 0, 32'h0,   0, 0);
      addRow(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   6'b000111, 0, 32'h0,   0, 0);

      @(negedge clk);
      repeat (2) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
         finishCycle();
      end

      // Directed table.
      foreach (rows[i]) begin
         applyStimulus(rows[i].r_rst, rows[i].r_id, rows[i].r_ex, rows[i].r_mem,
                       rows[i].r_exc, rows[i].r_eret, rows[i].r_vec, rows[i].r_epc);
         #1;
         checkOutput($sformatf("row%0d.stall", i), 32'(stall), 32'(rows[i].e_stall));
         checkOutput($sformatf("row%0d.flush", i), 32'(flush), 32'(rows[i].e_flush));
         checkOutput($sformatf("row%0d.new_pc", i), new_pc, rows[i].e_pc);
         checkOutput($sformatf("row%0d.stall_cnt", i), stall_cnt, rows[i].e_cnt);
         checkOutput($sformatf("row%0d.timeout", i), 32'(timeout), 32'(rows[i].e_to));
         finishCycle();
      end

      // Watchdog: memory stall held 10 cycles trips after the 4th stalled cycle.
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      finishCycle();
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1, 0, 0, 1, 0, 0, 32'h0, 32'h0);
         #1;
         checkOutput($sformatf("wd%0d.timeout", k), 32'(timeout), (k >= 5) ? 32'd1 : 32'd0);
         checkOutput($sformatf("wd%0d.stall", k), 32'(stall), 32'h1F);
         finishCycle();
      end
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
         #1;
         checkOutput($sformatf("wdhold%0d.timeout", k), 32'(timeout), 32'd1);
         checkOutput($sformatf("wdhold%0d.stall_cnt", k), stall_cnt, 32'd10);
         finishCycle();
      end
      // Timeout must not interfere with stalls or redirects.
      applyStimulus(1, 0, 1, 0, 1, 0, 32'h44, 32'h0);
      #1;
      checkOutput("wdexc.stall", 32'(stall), 32'h0F);
      finishCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      #1;
      checkOutput("wdexc.flush", 32'(flush), 32'd1);
      checkOutput("wdexc.new_pc", new_pc, 32'h44);
      finishCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      finishCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      #1;
      checkOutput("wdclr.timeout", 32'(timeout), 32'd0);
      checkOutput("wdclr.stall_cnt", stall_cnt, 32'd0);
      finishCycle();

      // Randomised traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(39) != 0,
                       $urandom_range(1) == 1,
                       $urandom_range(2) == 0,
                       $urandom_range(3) == 0,
                       $urandom_range(9) == 0,
                       $urandom_range(9) == 0,
                       $urandom, $urandom);
         #1;
         checkOutput($sformatf("rand%0d.stall", c), 32'(stall), 32'(modelStall()));
         checkOutput($sformatf("rand%0d.flush", c), 32'(flush), 32'(m_flush));
         checkOutput($sformatf("rand%0d.new_pc", c), new_pc, m_pc);
         checkOutput($sformatf("rand%0d.stall_cnt", c), stall_cnt, 32'(m_cnt));
         checkOutput($sformatf("rand%0d.timeout", c), 32'(timeout), 32'(m_to));
         finishCycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
